// File: rtl/scan_pkg.sv
// Shared types and defaults for the LIDAR pan/tilt scan sequencer.
package scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_STEP   = 2'd3
    } scan_state_t;

    // 20 ms frame, 1 ms base pulse, ~3.9 us per angle code at 50 MHz
    localparam int unsigned PWM_PERIOD_DEF = 1_000_000;
    localparam int unsigned PWM_BASE_DEF   = 50_000;
    localparam int unsigned PWM_LSB_DEF    = 196;

    localparam logic [7:0] ANGLE_RESET = 8'd128;

endpackage

// File: rtl/servo_pwm.sv
// Free-running servo PWM: fixed frame, pulse width taken from the angle at frame start.
module servo_pwm
    import scan_pkg::*;
#(
    parameter int unsigned PWM_PERIOD_CYC = PWM_PERIOD_DEF,
    parameter int unsigned PWM_BASE_CYC   = PWM_BASE_DEF,
    parameter int unsigned PWM_LSB_CYC    = PWM_LSB_DEF
)(
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] i_angle,
    output logic       o_pwm
);

    localparam int CW = (PWM_PERIOD_CYC > 1) ? $clog2(PWM_PERIOD_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD_CYC - 1);

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_width;
    logic          r_pwm;
    logic [31:0]   w_width;

    // Width is frozen for the whole frame so a mid-frame angle change never glitches the pulse
    assign w_width = (r_cnt == '0) ? (PWM_BASE_CYC + 32'(i_angle) * PWM_LSB_CYC) : r_width;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_width <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_width <= w_width;
            r_pwm   <= (32'(r_cnt) < w_width);
            r_cnt   <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/scan_sequencer.sv
// Raster scan of a pan/tilt servo head: settle, request a LIDAR sample, step, repeat.
//
// state    | meaning
// S_IDLE   | waiting for i_start; config checked here
// S_SETTLE | settle timer counting down after a move
// S_SAMPLE | o_sample_req held until i_sample_ack
// S_STEP   | advance yaw, wrap to next pitch row, or finish
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int unsigned PWM_PERIOD_CYC = PWM_PERIOD_DEF,
    parameter int unsigned PWM_BASE_CYC   = PWM_BASE_DEF,
    parameter int unsigned PWM_LSB_CYC    = PWM_LSB_DEF
)(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [7:0]  i_yaw_min,
    input  logic [7:0]  i_yaw_max,
    input  logic [7:0]  i_pitch_min,
    input  logic [7:0]  i_pitch_max,
    input  logic [7:0]  i_step,
    input  logic [23:0] i_settle_cyc,
    output logic        o_sample_req,
    input  logic        i_sample_ack,
    output logic [7:0]  o_yaw,
    output logic [7:0]  o_pitch,
    output logic        o_pwm_yaw,
    output logic        o_pwm_pitch,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_cfg_err,
    output logic [15:0] o_count
);

    scan_state_t r_state, w_state;
    logic [7:0]  r_yaw, w_yaw;
    logic [7:0]  r_pitch, w_pitch;
    logic [15:0] r_count, w_count;
    logic [23:0] r_settle, w_settle;
    logic        r_done, w_done;
    logic        r_cfg_err, w_cfg_err;
    logic        w_latch;

    logic [7:0]  r_yaw_min, r_yaw_max, r_pitch_max, r_step;
    logic [23:0] r_settle_cfg;

    logic        w_cfg_ok;
    logic [8:0]  w_yaw_sum, w_pitch_sum;

    assign w_cfg_ok    = (i_step != 8'd0) && (i_yaw_min <= i_yaw_max) && (i_pitch_min <= i_pitch_max);
    // One extra bit so a step past 255 reads as out of range instead of wrapping
    assign w_yaw_sum   = {1'b0, r_yaw} + {1'b0, r_step};
    assign w_pitch_sum = {1'b0, r_pitch} + {1'b0, r_step};

    always_comb begin
        w_state   = r_state;
        w_yaw     = r_yaw;
        w_pitch   = r_pitch;
        w_count   = r_count;
        w_settle  = r_settle;
        w_done    = 1'b0;
        w_cfg_err = 1'b0;
        w_latch   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_cfg_ok) begin
                        w_latch  = 1'b1;
                        w_yaw    = i_yaw_min;
                        w_pitch  = i_pitch_min;
                        w_count  = 16'd0;
                        w_settle = i_settle_cyc;
                        w_state  = S_SETTLE;
                    end else begin
                        w_cfg_err = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (r_settle == 24'd0) begin
                    w_state = S_SAMPLE;
                end else begin
                    w_settle = r_settle - 24'd1;
                end
            end
            S_SAMPLE: begin
                if (i_sample_ack) begin
                    if (r_count != 16'hFFFF) begin
                        w_count = r_count + 16'd1;
                    end
                    w_state = S_STEP;
                end
            end
            S_STEP: begin
                if (w_yaw_sum <= {1'b0, r_yaw_max}) begin
                    w_yaw    = w_yaw_sum[7:0];
                    w_settle = r_settle_cfg;
                    w_state  = S_SETTLE;
                end else if (w_pitch_sum <= {1'b0, r_pitch_max}) begin
                    w_yaw    = r_yaw_min;
                    w_pitch  = w_pitch_sum[7:0];
                    w_settle = r_settle_cfg;
                    w_state  = S_SETTLE;
                end else begin
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Abort beats everything, including an ack landing on the same cycle
        if (i_abort && (r_state != S_IDLE)) begin
            w_state  = S_IDLE;
            w_yaw    = r_yaw;
            w_pitch  = r_pitch;
            w_count  = r_count;
            w_settle = r_settle;
            w_done   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_yaw     <= ANGLE_RESET;
            r_pitch   <= ANGLE_RESET;
            r_count   <= 16'd0;
            r_settle  <= 24'd0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_yaw     <= w_yaw;
            r_pitch   <= w_pitch;
            r_count   <= w_count;
            r_settle  <= w_settle;
            r_done    <= w_done;
            r_cfg_err <= w_cfg_err;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_yaw_min    <= 8'd0;
            r_yaw_max    <= 8'd0;
            r_pitch_max  <= 8'd0;
            r_step       <= 8'd0;
            r_settle_cfg <= 24'd0;
        end else if (w_latch) begin
            r_yaw_min    <= i_yaw_min;
            r_yaw_max    <= i_yaw_max;
            r_pitch_max  <= i_pitch_max;
            r_step       <= i_step;
            r_settle_cfg <= i_settle_cyc;
        end
    end

    assign o_sample_req = (r_state == S_SAMPLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_cfg_err    = r_cfg_err;
    assign o_yaw        = r_yaw;
    assign o_pitch      = r_pitch;
    assign o_count      = r_count;

    servo_pwm #(
        .PWM_PERIOD_CYC (PWM_PERIOD_CYC),
        .PWM_BASE_CYC   (PWM_BASE_CYC),
        .PWM_LSB_CYC    (PWM_LSB_CYC)
    ) u_pwm_yaw (
        .clk     (clk),
        .rstn    (rstn),
        .i_angle (r_yaw),
        .o_pwm   (o_pwm_yaw)
    );

    servo_pwm #(
        .PWM_PERIOD_CYC (PWM_PERIOD_CYC),
        .PWM_BASE_CYC   (PWM_BASE_CYC),
        .PWM_LSB_CYC    (PWM_LSB_CYC)
    ) u_pwm_pitch (
        .clk     (clk),
        .rstn    (rstn),
        .i_angle (r_pitch),
        .o_pwm   (o_pwm_pitch)
    );

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with shortened PWM frame (600 cycles, base 20, 2 per LSB).
module tb_scan_sequencer;

    localparam int P    = 600;
    localparam int BASE = 20;
    localparam int LSB  = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [7:0]  i_yaw_min = '0, i_yaw_max = '0, i_pitch_min = '0, i_pitch_max = '0, i_step = '0;
    logic [23:0] i_settle_cyc = '0;
    logic        i_sample_ack = 1'b0;
    logic        o_sample_req, o_pwm_yaw, o_pwm_pitch, o_busy, o_done, o_cfg_err;
    logic [7:0]  o_yaw, o_pitch;
    logic [15:0] o_count;

    int total = 0;
    int bad   = 0;

    scan_sequencer #(
        .PWM_PERIOD_CYC (P),
        .PWM_BASE_CYC   (BASE),
        .PWM_LSB_CYC    (LSB)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_yaw_min    (i_yaw_min),
        .i_yaw_max    (i_yaw_max),
        .i_pitch_min  (i_pitch_min),
        .i_pitch_max  (i_pitch_max),
        .i_step       (i_step),
        .i_settle_cyc (i_settle_cyc),
        .o_sample_req (o_sample_req),
        .i_sample_ack (i_sample_ack),
        .o_yaw        (o_yaw),
        .o_pitch      (o_pitch),
        .o_pwm_yaw    (o_pwm_yaw),
        .o_pwm_pitch  (o_pwm_pitch),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_cfg_err    (o_cfg_err),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ymin, ymax, pmin, pmax, step;
        logic [23:0] settle;
        logic        exp_err;
        int          exp_n;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pwm_of(input bit sel);
        return sel ? o_pwm_pitch : o_pwm_yaw;
    endfunction

    task automatic set_cfg(input logic [7:0] ymin, ymax, pmin, pmax, step, input logic [23:0] settle);
        i_yaw_min = ymin; i_yaw_max = ymax; i_pitch_min = pmin; i_pitch_max = pmax;
        i_step = step; i_settle_cyc = settle;
    endtask

    task automatic wait_req(output int waited);
        waited = 0;
        while (!o_sample_req && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic wait_rise(input bit sel, output bit ok);
        logic prev;
        int n;
        prev = pwm_of(sel);
        ok = 1'b0;
        n = 0;
        while (!ok && n < 2 * P) begin
            @(negedge clk);
            n++;
            if (!prev && pwm_of(sel)) ok = 1'b1;
            prev = pwm_of(sel);
        end
    endtask

    task automatic measure(input bit sel, output int hi, output int per);
        bit ok;
        int lo;
        wait_rise(sel, ok);
        if (!ok) begin
            hi = -1; per = -1;
            return;
        end
        hi = 1;
        lo = 0;
        while (hi < P + 5) begin
            @(negedge clk);
            if (pwm_of(sel)) hi++; else break;
        end
        lo = 1;
        while (lo < P + 5) begin
            @(negedge clk);
            if (!pwm_of(sel)) lo++; else break;
        end
        per = hi + lo;
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] q[$];
        int w;
        for (int p = int'(v.pmin); p <= int'(v.pmax) && v.step != 0; p += int'(v.step))
            for (int y = int'(v.ymin); y <= int'(v.ymax); y += int'(v.step))
                q.push_back({y[7:0], p[7:0]});

        @(negedge clk);
        set_cfg(v.ymin, v.ymax, v.pmin, v.pmax, v.step, v.settle);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        if (v.exp_err) begin
            check("cfg_err_pulse", o_cfg_err, 1);
            check("cfg_err_busy", o_busy, 0);
            @(negedge clk);
            check("cfg_err_single", o_cfg_err, 0);
            check("cfg_err_idle", o_busy, 0);
            return;
        end
        check("start_busy", o_busy, 1);
        check("start_no_err", o_cfg_err, 0);
        check("start_pos", {o_yaw, o_pitch}, q[0]);
        check("start_count", o_count, 0);
        for (int k = 0; k < q.size(); k++) begin
            wait_req(w);
            check("req_latency", w, (k == 0) ? 32'(v.settle) + 1 : 32'(v.settle) + 2);
            if (!o_sample_req) return;
            check("sample_pos", {o_yaw, o_pitch}, q[k]);
            @(negedge clk);
            check("req_hold", o_sample_req, 1);
            @(negedge clk);
            check("req_hold2", o_sample_req, 1);
            i_sample_ack = 1'b1;
            @(negedge clk);
            i_sample_ack = 1'b0;
            check("req_drop", o_sample_req, 0);
            check("count_inc", o_count, k + 1);
        end
        w = 0;
        while (!o_done && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("done_latency", w, 1);
        check("busy_at_done", o_busy, 0);
        @(negedge clk);
        check("done_single", o_done, 0);
        check("final_count", o_count, v.exp_n);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, per, w, k;
        bit ok;

        vecs[0] = '{8'd0,   8'd20,  8'd0,   8'd10,  8'd10,  24'd4, 1'b0, 6};
        vecs[1] = '{8'd0,   8'd25,  8'd5,   8'd5,   8'd10,  24'd0, 1'b0, 3};
        vecs[2] = '{8'd0,   8'd20,  8'd0,   8'd10,  8'd0,   24'd1, 1'b1, 0};
        vecs[3] = '{8'd30,  8'd20,  8'd0,   8'd10,  8'd10,  24'd1, 1'b1, 0};
        vecs[4] = '{8'd0,   8'd20,  8'd10,  8'd5,   8'd5,   24'd1, 1'b1, 0};
        vecs[5] = '{8'd250, 8'd255, 8'd250, 8'd255, 8'd3,   24'd1, 1'b0, 4};
        vecs[6] = '{8'd7,   8'd7,   8'd9,   8'd9,   8'd255, 24'd2, 1'b0, 1};
        vecs[7] = '{8'd0,   8'd255, 8'd0,   8'd0,   8'd128, 24'd0, 1'b0, 2};
        vecs[8] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd1,   24'd0, 1'b0, 1};

        // Reset values while held in reset
        #12;
        check("rst_yaw", o_yaw, 128);
        check("rst_pitch", o_pitch, 128);
        check("rst_busy", o_busy, 0);
        check("rst_req", o_sample_req, 0);
        check("rst_done", o_done, 0);
        check("rst_cfg_err", o_cfg_err, 0);
        check("rst_count", o_count, 0);
        check("rst_pwm", {o_pwm_yaw, o_pwm_pitch}, 0);
        @(negedge clk);
        rstn = 1'b1;

        measure(1'b0, hi, per);
        check("pwm_rst_angle_hi", hi, BASE + 128 * LSB);
        check("pwm_rst_angle_per", per, P);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        measure(1'b0, hi, per);
        check("pwm_yaw255_hi", hi, BASE + 255 * LSB);
        check("pwm_yaw255_per", per, P);

        // Abort with simultaneous ack
        @(negedge clk);
        set_cfg(8'd0, 8'd20, 8'd0, 8'd0, 8'd10, 24'd0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_req(w);
        check("ab_pos0", {o_yaw, o_pitch}, {8'd0, 8'd0});
        i_sample_ack = 1'b1;
        @(negedge clk);
        i_sample_ack = 1'b0;
        wait_req(w);
        check("ab_req", o_sample_req, 1);
        check("ab_pos1", {o_yaw, o_pitch}, {8'd10, 8'd0});
        i_abort = 1'b1;
        i_sample_ack = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        i_sample_ack = 1'b0;
        check("ab_req_drop", o_sample_req, 0);
        check("ab_busy", o_busy, 0);
        check("ab_done", o_done, 0);
        check("ab_count", o_count, 1);
        check("ab_yaw", o_yaw, 10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ab_no_done", o_done, 0);
        end
        i_sample_ack = 1'b1;
        @(negedge clk);
        i_sample_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_ignored", o_count, 1);

        measure(1'b1, hi, per);
        check("pwm_pitch0_hi", hi, BASE);
        check("pwm_pitch0_per", per, P);

        // Mid-frame angle change: yaw 10 -> 200 during the high pulse
        wait_rise(1'b0, ok);
        check("mid_rise", ok, 1);
        hi = 1;
        k = 0;
        while (k < P + 5) begin
            if (k == 4) begin
                set_cfg(8'd200, 8'd200, 8'd0, 8'd0, 8'd1, 24'd0);
                i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
            k++;
            if (o_pwm_yaw) hi++; else break;
        end
        i_start = 1'b0;
        check("mid_frame_hi", hi, BASE + 10 * LSB);
        check("mid_yaw_changed", o_yaw, 200);
        measure(1'b0, hi, per);
        check("next_frame_hi", hi, BASE + 200 * LSB);
        @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("mid_abort_busy", o_busy, 0);

        // Start while busy ignored (even invalid), ack outside SAMPLE ignored
        @(negedge clk);
        set_cfg(8'd40, 8'd60, 8'd0, 8'd0, 8'd10, 24'd20);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        set_cfg(8'd100, 8'd120, 8'd0, 8'd0, 8'd0, 24'd0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_start_no_err", o_cfg_err, 0);
        check("busy_start_yaw", o_yaw, 40);
        check("busy_start_busy", o_busy, 1);
        i_sample_ack = 1'b1;
        @(negedge clk);
        i_sample_ack = 1'b0;
        check("settle_ack_count", o_count, 0);
        check("settle_ack_req", o_sample_req, 0);
        wait_req(w);
        check("d_req", o_sample_req, 1);
        check("d_yaw0", o_yaw, 40);
        i_sample_ack = 1'b1;
        @(negedge clk);
        i_sample_ack = 1'b0;
        wait_req(w);
        check("d_latency", w, 22);
        check("d_yaw1", o_yaw, 50);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("d_abort_busy", o_busy, 0);

        // Asynchronous reset mid-SETTLE
        @(negedge clk);
        set_cfg(8'd5, 8'd9, 8'd6, 8'd7, 8'd1, 24'd50);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", o_busy, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_busy", o_busy, 0);
        check("async_rst_yaw", o_yaw, 128);
        check("async_rst_pitch", o_pitch, 128);
        check("async_rst_count", o_count, 0);
        check("async_rst_pwm", {o_pwm_yaw, o_pwm_pitch}, 0);
        @(negedge clk);
        rstn = 1'b1;
        check("rel_pwm_low", o_pwm_yaw, 0);
        @(negedge clk);
        check("fresh_frame_pwm", o_pwm_yaw, 1);
        check("rel_idle", o_busy, 0);
        measure(1'b1, hi, per);
        check("post_rst_pitch_hi", hi, BASE + 128 * LSB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
